// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier with a start/busy/done handshake.
// Latency: done is high in the cycle after accept edge + N (N=W signed, W+1 unsigned).
// Backpressure: start is taken only while busy is low; start while busy is ignored.
// Optional feature macro: BOOTH_UNSIGNED_EN adds the 'sgn' port for unsigned operation.
module booth_seq_mult #(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef BOOTH_UNSIGNED_EN
  input  logic             sgn,
`endif
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   product
);

  localparam int CNT_W = $clog2(W+2);
`ifdef BOOTH_UNSIGNED_EN
  // One extra multiplier bit carries the zero extension for unsigned operands.
  localparam int QW = W + 1;
  localparam logic [CNT_W-1:0] LAST_U = CNT_W'(W);
`else
  localparam int QW = W;
`endif
  localparam logic [CNT_W-1:0] LAST_S = CNT_W'(W-1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [W:0]       m_q, m_d;       // multiplicand, one bit wider than the operand
  logic [W:0]       acc_q, acc_d;   // A: wide enough that A-M never overflows
  logic [QW-1:0]    q_q, q_d;       // multiplier / low product bits
  logic             qm1_q, qm1_d;   // Q-1 Booth look-behind bit
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]   prod_q, prod_d;
`ifdef BOOTH_UNSIGNED_EN
  logic             sgn_q, sgn_d;
`endif

  logic [W:0]       sum;
  logic [W:0]       sh_acc;
  logic [QW-1:0]    sh_q;
  logic             last;

  // Next state and datapath: load on accept, one Booth step per RUN cycle.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
`ifdef BOOTH_UNSIGNED_EN
    sgn_d   = sgn_q;
    last    = (cnt_q == (sgn_q ? LAST_S : LAST_U));
`else
    last    = (cnt_q == LAST_S);
`endif

    case ({q_q[0], qm1_q})
      2'b01:   sum = acc_q + m_q;
      2'b10:   sum = acc_q - m_q;
      default: sum = acc_q;
    endcase
    // Arithmetic right shift of {A,Q,Q-1}, replicating the sign of A.
    sh_acc = {sum[W], sum[W:1]};
    sh_q   = {sum[0], q_q[QW-1:1]};

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d = S_RUN;
          acc_d   = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
`ifdef BOOTH_UNSIGNED_EN
          sgn_d   = sgn;
          m_d     = sgn ? {a[W-1], a} : {1'b0, a};
          q_d     = sgn ? {b[W-1], b} : {1'b0, b};
`else
          m_d     = {a[W-1], a};
          q_d     = b;
`endif
        end
      end
      S_RUN: begin
        acc_d = sh_acc;
        q_d   = sh_q;
        qm1_d = q_q[0];
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          state_d = S_DONE;
`ifdef BOOTH_UNSIGNED_EN
          // Signed runs stop one shift short, so the product sits one bit higher in Q.
          prod_d = sgn_q ? {sh_acc[W-1:0], sh_q[QW-1:1]} : {sh_acc[W-2:0], sh_q};
`else
          prod_d = {sh_acc[W-1:0], sh_q};
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation and clears the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
`ifdef BOOTH_UNSIGNED_EN
      sgn_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
`ifdef BOOTH_UNSIGNED_EN
      sgn_q   <= sgn_d;
`endif
    end
  end

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign product = prod_q;

endmodule
